// File: rtl/bibus_pkg.sv
// Shared definitions for the bidirectional bus port: FSM encoding and turnaround limits.
package bibus_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WACK    = 3'd1,
        TURN    = 3'd2,
        DRIVE   = 3'd3,
        RELEASE = 3'd4
    } bibus_state_t;

    localparam int TURN_CYC_MIN = 1;
    localparam int TURN_CYC_MAX = 15;

    // Out-of-range turnaround settings are pinned to the nearest legal value so the 4-bit counter never wraps.
    function automatic int clamp_turn(input int cyc);
        if (cyc < TURN_CYC_MIN) return TURN_CYC_MIN;
        if (cyc > TURN_CYC_MAX) return TURN_CYC_MAX;
        return cyc;
    endfunction

endpackage

// File: rtl/bibus_tri_buf.sv
// Tristate pad driver for the shared 8-bit data bus.
module bibus_tri_buf (
    input  logic       oe,
    input  logic [7:0] d,
    inout  wire  [7:0] pad
);

    assign pad = oe ? d : 8'bz;

endmodule

// File: rtl/bibus_port_ctrl.sv
// Slave port on a shared bidirectional bus: captures master writes and returns the counter result on reads.
module bibus_port_ctrl
    import bibus_pkg::*;
#(
    parameter int TURN_CYC = 1
) (
    input  logic       clock,
    input  logic       reset,
    inout  wire  [7:0] data_bus,
    input  logic       wr_req,
    input  logic       rd_req,
    input  logic [7:0] cnt_in,
    output logic [7:0] data_bus_out,
    output logic       wr_ack,
    output logic       rd_valid,
    output logic       bus_oe,
    output logic       busy
);

    localparam int         TURN_EFF  = clamp_turn(TURN_CYC);
    localparam logic [3:0] TURN_LAST = 4'(TURN_EFF - 1);

    bibus_state_t state;
    bibus_state_t next_state;
    logic [7:0]   hold_reg;
    logic [7:0]   drive_reg;
    logic [3:0]   turn_cnt;
    logic         turn_done;
    logic         in_turn;

    assign in_turn   = (state == TURN) || (state == RELEASE);
    assign turn_done = (turn_cnt == TURN_LAST);

    // Requests are only looked at in IDLE; write has priority over read.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (wr_req)      next_state = WACK;
                else if (rd_req) next_state = TURN;
            end
            WACK:    if (!wr_req)  next_state = IDLE;
            TURN:    if (turn_done) next_state = DRIVE;
            DRIVE:   if (!rd_req)  next_state = RELEASE;
            RELEASE: if (turn_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            hold_reg  <= 8'h00;
            drive_reg <= 8'h00;
            turn_cnt  <= 4'd0;
            wr_ack    <= 1'b0;
            bus_oe    <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            state    <= next_state;
            wr_ack   <= (state == IDLE) && wr_req;
            bus_oe   <= (next_state == DRIVE);
            rd_valid <= (next_state == DRIVE);
            if ((state == IDLE) && wr_req)
                hold_reg <= data_bus;
            // Snapshot the counter result once so later cnt_in movement cannot corrupt the read.
            if ((state == TURN) && turn_done)
                drive_reg <= cnt_in;
            if (in_turn && !turn_done)
                turn_cnt <= turn_cnt + 4'd1;
            else
                turn_cnt <= 4'd0;
        end
    end

    assign data_bus_out = hold_reg;
    assign busy         = (state != IDLE);

    bibus_tri_buf u_tri_buf (
        .oe  (bus_oe),
        .d   (drive_reg),
        .pad (data_bus)
    );

endmodule

// File: tb/tb_bibus_port_ctrl.sv
// Directed bench for bibus_port_ctrl: one instance with TURN_CYC=1, one with TURN_CYC=3, each feeding a +1 counter model.
module tb_bibus_port_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    // Instance a: TURN_CYC = 1
    wire  [7:0] data_bus;
    logic       wr_req = 1'b0, rd_req = 1'b0;
    logic [7:0] cnt_in, data_bus_out;
    logic       wr_ack, rd_valid, bus_oe, busy;
    logic       tb_oe = 1'b0;
    logic [7:0] tb_data = 8'h00;
    logic [7:0] cnt_q = 8'h00;
    logic       ovr_en = 1'b0;
    logic [7:0] ovr_val = 8'h00;

    // Instance b: TURN_CYC = 3
    wire  [7:0] data_bus_b;
    logic       wr_req_b = 1'b0, rd_req_b = 1'b0;
    logic [7:0] data_bus_out_b;
    logic       wr_ack_b, rd_valid_b, bus_oe_b, busy_b;
    logic       tb_oe_b = 1'b0;
    logic [7:0] tb_data_b = 8'h00;
    logic [7:0] cnt_q_b = 8'h00;

    assign data_bus   = tb_oe   ? tb_data   : 8'bz;
    assign data_bus_b = tb_oe_b ? tb_data_b : 8'bz;
    assign cnt_in     = ovr_en  ? ovr_val   : cnt_q;

    always #5 clock = ~clock;

    // Downstream counter stage model: registered increment with natural 8-bit wrap.
    always @(posedge clock) begin
        cnt_q   <= data_bus_out + 8'd1;
        cnt_q_b <= data_bus_out_b + 8'd1;
    end

    bibus_port_ctrl #(.TURN_CYC(1)) dut (
        .clock(clock), .reset(reset), .data_bus(data_bus), .wr_req(wr_req), .rd_req(rd_req),
        .cnt_in(cnt_in), .data_bus_out(data_bus_out), .wr_ack(wr_ack), .rd_valid(rd_valid),
        .bus_oe(bus_oe), .busy(busy)
    );

    bibus_port_ctrl #(.TURN_CYC(3)) dut_b (
        .clock(clock), .reset(reset), .data_bus(data_bus_b), .wr_req(wr_req_b), .rd_req(rd_req_b),
        .cnt_in(cnt_q_b), .data_bus_out(data_bus_out_b), .wr_ack(wr_ack_b), .rd_valid(rd_valid_b),
        .bus_oe(bus_oe_b), .busy(busy_b)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (wr_ack !== 1'b0) begin failures++; $display("[TB] FAIL reset_wr_ack got=%b exp=0", wr_ack); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        checks++; if (bus_oe !== 1'b0) begin failures++; $display("[TB] FAIL reset_bus_oe got=%b exp=0", bus_oe); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (data_bus_out !== 8'h00) begin failures++; $display("[TB] FAIL reset_out got=%h exp=00", data_bus_out); end
        checks++; if (busy_b !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy_b got=%b exp=0", busy_b); end
        reset = 1'b0;
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_after_reset got=%b exp=0", busy); end
    endtask

    task automatic test_write();
        tb_oe = 1'b1; tb_data = 8'h41; wr_req = 1'b1;
        step();
        checks++; if (wr_ack !== 1'b1) begin failures++; $display("[TB] FAIL wr_ack_rise got=%b exp=1", wr_ack); end
        checks++; if (data_bus_out !== 8'h41) begin failures++; $display("[TB] FAIL wr_data got=%h exp=41", data_bus_out); end
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL wr_busy got=%b exp=1", busy); end
        tb_oe = 1'b0; wr_req = 1'b0;
        step();
        checks++; if (wr_ack !== 1'b0) begin failures++; $display("[TB] FAIL wr_ack_fall got=%b exp=0", wr_ack); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL wr_idle got=%b exp=0", busy); end
        checks++; if (cnt_q !== 8'h42) begin failures++; $display("[TB] FAIL wr_counter got=%h exp=42", cnt_q); end
    endtask

    task automatic test_read();
        rd_req = 1'b1;
        step();
        checks++; if (bus_oe !== 1'b0) begin failures++; $display("[TB] FAIL rd_turn_oe got=%b exp=0", bus_oe); end
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL rd_turn_busy got=%b exp=1", busy); end
        step();
        checks++; if (bus_oe !== 1'b1) begin failures++; $display("[TB] FAIL rd_drive_oe got=%b exp=1", bus_oe); end
        checks++; if (rd_valid !== 1'b1) begin failures++; $display("[TB] FAIL rd_valid got=%b exp=1", rd_valid); end
        checks++; if (data_bus !== 8'h42) begin failures++; $display("[TB] FAIL rd_data got=%h exp=42", data_bus); end
        // cnt_in moves and a stray write request arrive mid-DRIVE; neither may disturb the port.
        ovr_en = 1'b1; ovr_val = 8'h99; wr_req = 1'b1;
        step();
        checks++; if (data_bus !== 8'h42) begin failures++; $display("[TB] FAIL rd_hold_data got=%h exp=42", data_bus); end
        checks++; if (wr_ack !== 1'b0) begin failures++; $display("[TB] FAIL rd_ignore_wr got=%b exp=0", wr_ack); end
        checks++; if (data_bus_out !== 8'h41) begin failures++; $display("[TB] FAIL rd_hold_out got=%h exp=41", data_bus_out); end
        rd_req = 1'b0; wr_req = 1'b0;
        step();
        checks++; if (bus_oe !== 1'b0) begin failures++; $display("[TB] FAIL rel_oe got=%b exp=0", bus_oe); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL rel_valid got=%b exp=0", rd_valid); end
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL rel_busy got=%b exp=1", busy); end
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rd_done got=%b exp=0", busy); end
        ovr_en = 1'b0;
    endtask

    task automatic test_simultaneous();
        tb_oe = 1'b1; tb_data = 8'h10; wr_req = 1'b1; rd_req = 1'b1;
        step();
        checks++; if (wr_ack !== 1'b1) begin failures++; $display("[TB] FAIL sim_wr_ack got=%b exp=1", wr_ack); end
        checks++; if (data_bus_out !== 8'h10) begin failures++; $display("[TB] FAIL sim_wr_data got=%h exp=10", data_bus_out); end
        tb_oe = 1'b0;
        step();
        checks++; if (wr_ack !== 1'b0) begin failures++; $display("[TB] FAIL sim_ack_once got=%b exp=0", wr_ack); end
        checks++; if (busy !== 1'b1 || bus_oe !== 1'b0) begin failures++; $display("[TB] FAIL sim_wack got busy=%b oe=%b exp busy=1 oe=0", busy, bus_oe); end
        wr_req = 1'b0;
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL sim_back_idle got=%b exp=0", busy); end
        step();
        checks++; if (busy !== 1'b1 || bus_oe !== 1'b0) begin failures++; $display("[TB] FAIL sim_turn got busy=%b oe=%b exp busy=1 oe=0", busy, bus_oe); end
        step();
        checks++; if (data_bus !== 8'h11 || bus_oe !== 1'b1) begin failures++; $display("[TB] FAIL sim_drive got data=%h oe=%b exp data=11 oe=1", data_bus, bus_oe); end
    endtask

    task automatic test_reset_mid_drive();
        #2 reset = 1'b1;
        #1;
        checks++; if (bus_oe !== 1'b0) begin failures++; $display("[TB] FAIL rst_oe got=%b exp=0", bus_oe); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_valid got=%b exp=0", rd_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (data_bus_out !== 8'h00) begin failures++; $display("[TB] FAIL rst_out got=%h exp=00", data_bus_out); end
        tb_oe = 1'b1; tb_data = 8'hA5;
        #1;
        checks++; if (data_bus !== 8'hA5) begin failures++; $display("[TB] FAIL rst_bus_released got=%h exp=a5", data_bus); end
        tb_oe = 1'b0; rd_req = 1'b0;
        #1 reset = 1'b0;
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_restart_idle got=%b exp=0", busy); end
    endtask

    task automatic test_wrap_turn3();
        tb_oe_b = 1'b1; tb_data_b = 8'hFF; wr_req_b = 1'b1;
        step();
        checks++; if (wr_ack_b !== 1'b1) begin failures++; $display("[TB] FAIL wrap_ack got=%b exp=1", wr_ack_b); end
        checks++; if (data_bus_out_b !== 8'hFF) begin failures++; $display("[TB] FAIL wrap_out got=%h exp=ff", data_bus_out_b); end
        tb_oe_b = 1'b0; wr_req_b = 1'b0;
        step();
        checks++; if (cnt_q_b !== 8'h00) begin failures++; $display("[TB] FAIL wrap_counter got=%h exp=00", cnt_q_b); end
        rd_req_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus_oe_b !== 1'b0 || busy_b !== 1'b1) begin failures++; $display("[TB] FAIL turn3_cycle%0d got oe=%b busy=%b exp oe=0 busy=1", i, bus_oe_b, busy_b); end
        end
        step();
        checks++; if (bus_oe_b !== 1'b1 || rd_valid_b !== 1'b1) begin failures++; $display("[TB] FAIL turn3_drive got oe=%b valid=%b exp 1 1", bus_oe_b, rd_valid_b); end
        checks++; if (data_bus_b !== 8'h00) begin failures++; $display("[TB] FAIL turn3_data got=%h exp=00", data_bus_b); end
        rd_req_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus_oe_b !== 1'b0 || busy_b !== 1'b1) begin failures++; $display("[TB] FAIL rel3_cycle%0d got oe=%b busy=%b exp oe=0 busy=1", i, bus_oe_b, busy_b); end
        end
        step();
        checks++; if (busy_b !== 1'b0) begin failures++; $display("[TB] FAIL rel3_done got=%b exp=0", busy_b); end
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        test_write();
        test_read();
        test_simultaneous();
        test_reset_mid_drive();
        test_wrap_turn3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
